fir_coef_axil_regs: RTL and testbench
=====================================

FIR_COEF_AXIL_REGS -- requirements
Module: fir_coef_axil_regs

Interface
REQ-001 Parameter DATA_WIDTH, default 32, AXI4-Lite data width; only 32 and 64 are legal.
REQ-002 Parameter ADDR_WIDTH, default 8, byte address width.
REQ-003 Parameter NUM_COEF, default 8, number of coefficient registers (1..32).
REQ-004 ACLK  in  1  single clock; all state changes on its rising edge.
REQ-005 ARESETN  in  1  asynchronous active-low reset.
REQ-006 S_AXI_AWADDR/AWPROT/AWVALID in, AWREADY out  ADDR_WIDTH/3/1/1  write-address channel; AWPROT is ignored.
REQ-007 S_AXI_WDATA/WSTRB/WVALID in, WREADY out  DATA_WIDTH/DATA_WIDTH/8/1/1  write-data channel.
REQ-008 S_AXI_BRESP/BVALID out, BREADY in  2/1/1  write-response channel.
REQ-009 S_AXI_ARADDR/ARPROT/ARVALID in, ARREADY out  ADDR_WIDTH/3/1/1  read-address channel; ARPROT is ignored.
REQ-010 S_AXI_RDATA/RRESP/RVALID out, RREADY in  DATA_WIDTH/2/1/1  read-data channel.
REQ-011 fir_busy  in  1  status from the FIR datapath.
REQ-012 fir_enable  out  1  equals CTRL[0].
REQ-013 coef_out  out  NUM_COEF*DATA_WIDTH  active coefficients; coefficient i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 coef_update  out  1  one-cycle pulse when coef_out changes.

Function
REQ-015 Register map (word index = addr>>2): 0 CTRL (RW; bit0 enable, bit1 commit), 1 STATUS (RO; bit0 fir_busy, bits[15:8] commit count), 2..3 reserved, 4..4+NUM_COEF-1 COEF[i] (RW).
REQ-016 AW and W are accepted independently: AWREADY=1 while no address is latched and BVALID=0; WREADY=1 while no data is latched and BVALID=0.
REQ-017 The write executes on the cycle after both AW and W are latched; BVALID rises on that same cycle and holds, with BRESP stable, until BVALID&BREADY.
REQ-018 Each byte lane is written only when its WSTRB bit is set; WSTRB=0 writes nothing and returns OKAY.
REQ-019 A write to STATUS, a reserved word, or an index >= 4+NUM_COEF changes no state and returns BRESP=SLVERR (2'b10).
REQ-020 ARREADY=1 while RVALID=0; RVALID rises the cycle after AR is accepted; RDATA/RRESP hold stable until RVALID&RREADY.
REQ-021 A read of an unmapped index returns RDATA=0 and RRESP=SLVERR; CTRL[1] always reads 0.
REQ-022 A read accepted in the same cycle that a write executes to the same register returns the pre-write value.
REQ-023 Writing CTRL with bit1=1 (lane 0 strobed) is a commit: CTRL[1] self-clears, the commit count increments and wraps 255->0, and coef_update pulses on the following cycle.
REQ-024 Back-to-back commits on consecutive writes each produce their own coef_update pulse and count increment.

Reset
REQ-025 While ARESETN=0: all READY and VALID outputs are 0, BRESP=RRESP=0, RDATA=0, CTRL=0, all COEF=0, the commit count is 0, coef_out=0, and coef_update=0.
REQ-026 Reset asserted mid-transaction discards latched AW/W/AR state without generating a response; after release AWREADY, WREADY and ARREADY are 1 on the first clock edge.

Configuration
REQ-027 Macro FIR_COEF_SHADOW_EN, when defined: COEF[i] writes go to shadow registers (readback returns the shadow value), and coef_out loads all shadows atomically on commit, together with the coef_update pulse.
REQ-028 When FIR_COEF_SHADOW_EN is undefined: coef_out follows COEF[i] directly, and coef_update pulses the cycle after any COEF write that has a nonzero WSTRB; a commit still increments the count.

Verification
REQ-029 Write COEF[0..3]=1,2,3,4 (addr 0x10..0x1C), then read back -> RDATA 1,2,3,4 with OKAY, matching the existing four-register sequential test.
REQ-030 Issue W two cycles before AW, with BREADY held low for 3 cycles -> a single write occurs, BVALID stays asserted for 4 cycles, and AWREADY/WREADY stay 0 meanwhile.
REQ-031 Write 0xAABBCCDD to COEF[1], then WSTRB=4'b0010 with data 0x00001100 -> readback 0xAABB11DD.
REQ-032 Write to 0x04 and read from 0xFC -> both return SLVERR; the read returns RDATA=0 and STATUS is unchanged.
REQ-033 With FIR_COEF_SHADOW_EN defined: write COEF[2]=5 -> coef_out slice 2 stays 0; write CTRL=0x2 -> slice 2 becomes 5, coef_update pulses once, and STATUS[15:8]=1; 256 commits -> count reads 0.
REQ-034 Assert ARESETN low while BVALID=1 -> BVALID=0 immediately; after release a new write completes normally.

Source files
------------

// File: rtl/fir_coef_axil_regs_if.sv
// AXI4-Lite bundle for the FIR coefficient register block.
// Parameters: DATA_WIDTH (32 or 64), ADDR_WIDTH (byte address width).
// Modports:
//   master - drives AW/W/AR payload and valids, BREADY and RREADY
//   slave  - drives AWREADY/WREADY/ARREADY, B and R channel outputs
interface fir_coef_axil_regs_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/fir_coef_axil_regs.sv
// AXI4-Lite register block holding FIR coefficients, a control register
// and a status register.
// Ports:
//   ACLK, ARESETN   - clock, asynchronous active-low reset
//   s_axi           - AXI4-Lite slave (fir_coef_axil_regs_if.slave)
//   fir_busy        - datapath status, visible in STATUS[0]
//   fir_enable      - CTRL[0]
//   coef_out        - active coefficients, coef i at [i*DATA_WIDTH +: DATA_WIDTH]
//   coef_update     - one-cycle pulse in the cycle coef_out takes new values
// Word map: 0 CTRL (bit0 enable, bit1 commit), 1 STATUS (bit0 busy,
// [15:8] commit count), 2..3 reserved, 4.. COEF[i].
// Build option FIR_COEF_SHADOW_EN: COEF writes land in shadow registers and
// coef_out loads them all on commit. Without it coef_out tracks COEF directly.
// DATA_WIDTH must be 32 or 64.
module fir_coef_axil_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_COEF   = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  fir_coef_axil_regs_if.slave            s_axi,
  input  logic                           fir_busy,
  output logic                           fir_enable,
  output logic [NUM_COEF*DATA_WIDTH-1:0] coef_out,
  output logic                           coef_update
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  ready_en;
  logic                  aw_full;
  logic [IDX_W-1:0]      aw_idx;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ctrl_en;
  logic [7:0]            commit_cnt;
  logic [DATA_WIDTH-1:0] coef_q [NUM_COEF];
  logic                  coef_upd_q;

  logic                  wr_exec, wr_is_ctrl, wr_is_coef, commit, upd_next;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] rd_val;
  int                    wr_word, rd_word;
  logic                  unused_bits;

  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // ready_en keeps every READY low during reset and rises on the first edge after release
  assign s_axi.awready = ready_en & ~aw_full & ~bvalid_q;
  assign s_axi.wready  = ready_en & ~w_full & ~bvalid_q;
  assign s_axi.arready = ready_en & ~rvalid_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;
  assign fir_enable    = ctrl_en;
  assign coef_update   = coef_upd_q;

  always_comb begin
    wr_word    = int'(aw_idx);
    wr_exec    = aw_full & w_full;
    wr_is_ctrl = (wr_word == 0);
    wr_is_coef = (wr_word >= 4) && (wr_word < 4 + NUM_COEF);
    commit     = wr_exec & wr_is_ctrl & wstrb_q[0] & wdata_q[1];
  end

`ifdef FIR_COEF_SHADOW_EN
  assign upd_next = commit;
`else
  assign upd_next = commit | (wr_exec & wr_is_coef & (|wstrb_q));
`endif

  // Read mux is evaluated on the pre-edge register values, so a read accepted
  // on the edge that executes a write sees the old contents.
  always_comb begin
    rd_word = int'(s_axi.araddr[ADDR_WIDTH-1:2]);
    rd_val  = '0;
    rd_ok   = 1'b1;
    if (rd_word == 0) begin
      rd_val[0] = ctrl_en;
    end else if (rd_word == 1) begin
      rd_val[0]    = fir_busy;
      rd_val[15:8] = commit_cnt;
    end else if ((rd_word >= 4) && (rd_word < 4 + NUM_COEF)) begin
      for (int i = 0; i < NUM_COEF; i++)
        if (rd_word == i + 4) rd_val = coef_q[i];
    end else begin
      rd_ok = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en   <= 1'b0;
      aw_full    <= 1'b0;
      aw_idx     <= '0;
      w_full     <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      ctrl_en    <= 1'b0;
      commit_cnt <= '0;
      coef_upd_q <= 1'b0;
      for (int i = 0; i < NUM_COEF; i++) coef_q[i] <= '0;
    end else begin
      ready_en   <= 1'b1;
      coef_upd_q <= upd_next;

      if (s_axi.awvalid && s_axi.awready) begin
        aw_full <= 1'b1;
        aw_idx  <= s_axi.awaddr[ADDR_WIDTH-1:2];
      end
      if (s_axi.wvalid && s_axi.wready) begin
        w_full  <= 1'b1;
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end

      if (wr_exec) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= (wr_is_ctrl || wr_is_coef) ? RESP_OKAY : RESP_SLVERR;
        if (wr_is_ctrl && wstrb_q[0]) ctrl_en <= wdata_q[0];
        if (commit) commit_cnt <= commit_cnt + 8'd1;
        for (int i = 0; i < NUM_COEF; i++)
          for (int b = 0; b < STRB_W; b++)
            if ((wr_word == i + 4) && wstrb_q[b])
              coef_q[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end else if (bvalid_q && s_axi.bready) begin
        bvalid_q <= 1'b0;
      end

      if (s_axi.arvalid && s_axi.arready) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
        rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && s_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

`ifdef FIR_COEF_SHADOW_EN
  logic [DATA_WIDTH-1:0] active_q [NUM_COEF];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_COEF; i++) active_q[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_COEF; i++) active_q[i] <= coef_q[i];
    end
  end

  always_comb begin
    coef_out = '0;
    for (int i = 0; i < NUM_COEF; i++) coef_out[i*DATA_WIDTH +: DATA_WIDTH] = active_q[i];
  end
`else
  always_comb begin
    coef_out = '0;
    for (int i = 0; i < NUM_COEF; i++) coef_out[i*DATA_WIDTH +: DATA_WIDTH] = coef_q[i];
  end
`endif
endmodule

// File: tb/tb_fir_coef_axil_regs.sv
// Directed self-checking bench for fir_coef_axil_regs (DATA_WIDTH 32,
// ADDR_WIDTH 8, NUM_COEF 8). Shadow-specific expectations are selected with
// FIR_COEF_SHADOW_EN, matching the build of the design.
module tb_fir_coef_axil_regs;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NC = 8;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic          fir_busy;
  logic          fir_enable;
  logic [NC*DW-1:0] coef_out;
  logic          coef_update;

  int n_assert = 0;
  int n_fail   = 0;

  fir_coef_axil_regs_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fir_coef_axil_regs #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_COEF(NC)) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .s_axi       (bus),
    .fir_busy    (fir_busy),
    .fir_enable  (fir_enable),
    .coef_out    (coef_out),
    .coef_update (coef_update)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns at a falling edge.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic upd);
    int t;
    logic aw_pend, w_pend, aw_go, w_go;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    aw_pend = 1'b1; w_pend = 1'b1; t = 0;
    while ((aw_pend || w_pend) && t < 20) begin
      aw_go = aw_pend & bus.awready;
      w_go  = w_pend & bus.wready;
      @(negedge ACLK); t++;
      if (aw_go) begin bus.awvalid = 1'b0; aw_pend = 1'b0; end
      if (w_go)  begin bus.wvalid  = 1'b0; w_pend  = 1'b0; end
    end
    chk("wr_accept_timeout", {62'd0, aw_pend, w_pend}, 64'd0);
    t = 0;
    while (!bus.bvalid && t < 20) begin @(negedge ACLK); t++; end
    chk("wr_bvalid_timeout", bus.bvalid, 1);
    resp = bus.bresp;
    upd  = coef_update;
    bus.bready = 1'b1;
    @(negedge ACLK);
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int t;
    bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b0;
    t = 0;
    while (!bus.arready && t < 20) begin @(negedge ACLK); t++; end
    @(negedge ACLK);
    bus.arvalid = 1'b0;
    t = 0;
    while (!bus.rvalid && t < 20) begin @(negedge ACLK); t++; end
    chk("rd_rvalid_timeout", bus.rvalid, 1);
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    @(negedge ACLK);
    bus.rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic        upd;
    logic [31:0] rd;
    int          npulse, bcnt, rdy_bad;

    ARESETN = 1'b0; fir_busy = 1'b0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state
    repeat (3) @(negedge ACLK);
    chk("rst_awready", bus.awready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_bresp_rresp", {bus.bresp, bus.rresp}, 0);
    chk("rst_coef_out", coef_out[63:0] | coef_out[255:192], 0);
    chk("rst_coef_update", coef_update, 0);
    chk("rst_fir_enable", fir_enable, 0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("post_rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);

    // COEF[0..3] = 1..4 and readback
    for (int i = 0; i < 4; i++) begin
      axi_write(8'h10 + 8'(i * 4), 32'(i + 1), 4'hF, resp, upd);
      chk("coef_wr_resp", resp, OKAY);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(8'h10 + 8'(i * 4), rd, resp);
      chk("coef_rd_data", rd, 32'(i + 1));
      chk("coef_rd_resp", resp, OKAY);
    end

    // Shadow versus direct coefficient path, then first commit
`ifdef FIR_COEF_SHADOW_EN
    chk("shadow_slice2_before", coef_out[2*DW +: DW], 0);
    axi_write(8'h18, 32'd5, 4'hF, resp, upd);
    chk("shadow_coef_wr_no_upd", upd, 0);
    chk("shadow_slice2_held", coef_out[2*DW +: DW], 0);
`else
    chk("direct_slice2", coef_out[2*DW +: DW], 3);
    axi_write(8'h18, 32'd5, 4'hF, resp, upd);
    chk("direct_coef_wr_upd", upd, 1);
    chk("direct_slice2_new", coef_out[2*DW +: DW], 5);
`endif
    chk("upd_one_cycle", coef_update, 0);
    axi_write(8'h00, 32'h2, 4'h1, resp, upd);
    chk("commit_resp", resp, OKAY);
    chk("commit_upd", upd, 1);
    chk("commit_slice2", coef_out[2*DW +: DW], 5);
    chk("commit_slice0", coef_out[0 +: DW], 1);
    chk("commit_enable_off", fir_enable, 0);
    axi_read(8'h04, rd, resp);
    chk("status_cnt1", rd, 32'h0000_0100);
    axi_read(8'h18, rd, resp);
    chk("coef2_readback", rd, 5);

    // Enable plus commit; commit bit reads back 0
    axi_write(8'h00, 32'h3, 4'h1, resp, upd);
    chk("ctrl_commit2_upd", upd, 1);
    chk("fir_enable_on", fir_enable, 1);
    axi_read(8'h00, rd, resp);
    chk("ctrl_rd", rd, 1);
    axi_read(8'h04, rd, resp);
    chk("status_cnt2", rd, 32'h0000_0200);

    // Byte strobes
    axi_write(8'h14, 32'hAABBCCDD, 4'hF, resp, upd);
    axi_write(8'h14, 32'h00001100, 4'b0010, resp, upd);
    axi_read(8'h14, rd, resp);
    chk("strobe_merge", rd, 32'hAABB11DD);
    axi_write(8'h20, 32'hFFFFFFFF, 4'h0, resp, upd);
    chk("strb0_resp", resp, OKAY);
    chk("strb0_no_upd", upd, 0);
    axi_read(8'h20, rd, resp);
    chk("strb0_no_write", rd, 0);

    // Error responses
    axi_write(8'h04, 32'hFFFFFFFF, 4'hF, resp, upd);
    chk("status_wr_slverr", resp, SLVERR);
    axi_write(8'h30, 32'h12345678, 4'hF, resp, upd);
    chk("oob_wr_slverr", resp, SLVERR);
    axi_read(8'hFC, rd, resp);
    chk("unmapped_rd_resp", resp, SLVERR);
    chk("unmapped_rd_data", rd, 0);
    axi_read(8'h08, rd, resp);
    chk("reserved_rd_resp", resp, SLVERR);
    axi_read(8'h2C, rd, resp);
    chk("last_coef_rd_resp", resp, OKAY);
    fir_busy = 1'b1;
    axi_read(8'h04, rd, resp);
    chk("status_unchanged_busy", rd, 32'h0000_0201);
    fir_busy = 1'b0;

    // Read accepted on the write-execute edge sees the old value
    bus.awaddr = 8'h24; bus.awvalid = 1'b1;
    bus.wdata = 32'h77; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge ACLK);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 8'h24; bus.arvalid = 1'b1;
    @(negedge ACLK);
    bus.arvalid = 1'b0;
    chk("raw_bvalid", bus.bvalid, 1);
    chk("raw_rvalid", bus.rvalid, 1);
    chk("raw_old_value", bus.rdata, 0);
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(negedge ACLK);
    bus.bready = 1'b0; bus.rready = 1'b0;
    axi_read(8'h24, rd, resp);
    chk("raw_new_value", rd, 32'h77);

    // W two cycles ahead of AW, BREADY low for three cycles
    bus.wdata = 32'h66; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge ACLK);
    bus.wvalid = 1'b0;
    chk("early_w_latched", {bus.wready, bus.awready}, 2'b01);
    @(negedge ACLK);
    bus.awaddr = 8'h28; bus.awvalid = 1'b1;
    @(negedge ACLK);
    bus.awvalid = 1'b0;
    bcnt = 0; rdy_bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge ACLK);
      if (bus.bvalid) begin
        bcnt++;
        if (bus.awready || bus.wready) rdy_bad++;
        if (bus.bresp !== OKAY) rdy_bad++;
      end
      bus.bready = (bcnt >= 4);
    end
    bus.bready = 1'b0;
    chk("bvalid_hold_cycles", bcnt, 4);
    chk("ready_low_during_b", rdy_bad, 0);
    axi_read(8'h28, rd, resp);
    chk("early_w_data", rd, 32'h66);

    // Back-to-back commits wrap the count
    npulse = 0;
    for (int k = 0; k < 254; k++) begin
      axi_write(8'h00, 32'h3, 4'h1, resp, upd);
      if (upd) npulse++;
    end
    chk("commit_pulses", npulse, 254);
    axi_read(8'h04, rd, resp);
    chk("status_cnt_wrap", rd, 0);

    // Reset while BVALID is high
    bus.awaddr = 8'h10; bus.awvalid = 1'b1;
    bus.wdata = 32'h55; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge ACLK);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge ACLK);
    chk("pre_rst_bvalid", bus.bvalid, 1);
    #2 ARESETN = 1'b0;
    #1 chk("rst_kills_bvalid", bus.bvalid, 0);
    chk("rst_mid_awready", bus.awready, 0);
    @(negedge ACLK);
    chk("rst_mid_coef_out", coef_out[0 +: DW], 0);
    chk("rst_mid_enable", fir_enable, 0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("rst2_ready", {bus.awready, bus.wready, bus.arready, bus.bvalid}, 4'b1110);
    axi_write(8'h10, 32'h99, 4'hF, resp, upd);
    chk("post_rst_wr_resp", resp, OKAY);
    axi_read(8'h10, rd, resp);
    chk("post_rst_rd", rd, 32'h99);
    axi_read(8'h14, rd, resp);
    chk("post_rst_coef1_cleared", rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
